sram_sp_arb_2m: RTL and testbench
=================================

Name: sram_sp_arb_2m

Overview:
- Two-master arbiter and sequencer for the single-port 16384x32 byte-enabled SoC SRAM wrapper.
- Shares the one SRAM port between master 0 (instruction fetch) and master 1 (load/store), one access per cycle.
- Converts active-high master requests into the wrapper's active-low CEN/GWEN/BEN controls.
- Returns read data with fixed latency and tags it to the master that issued the read.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins.
- REG_OUT, 0, 0 = read data is the SRAM Q passed through; 1 = read data registered one extra stage.

Ports:
- CLK  input  1  clock, rising edge; same clock as the SRAM.
- RST  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request valid.
- m0_ready  output  1  master 0 request accepted this cycle.
- m0_we  input  1  1 = write, 0 = read.
- m0_be  input  4  byte enables, active-high; bit i covers data bits [8i+7:8i].
- m0_addr  input  14  word address.
- m0_wdata  input  32  write data.
- m0_rvalid  output  1  read data valid for master 0.
- m0_rdata  output  32  read data for master 0.
- m1_req, m1_ready, m1_we, m1_be, m1_addr, m1_wdata, m1_rvalid, m1_rdata: same as master 0, for master 1.
- sram_q  input  32  SRAM read data (wrapper Q).
- SRAM_CEN  output  1  chip enable to wrapper, active-low.
- SRAM_GWEN  output  1  global write enable, active-low.
- SRAM_BEN  output  4  byte enables, active-low.
- SRAM_A  output  14  address.
- SRAM_D  output  32  write data.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous, active-high. All state updates on the CLK rising edge.
- Reset values while RST=1:
  - SRAM_CEN=1, SRAM_GWEN=1, SRAM_BEN=4'hF, SRAM_A=0, SRAM_D=0.
  - m0_ready=m1_ready=0.
  - m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0.
  - Round-robin pointer = 0, meaning master 0 wins the next tie.
  - Any read in flight when RST rises is discarded; no rvalid is produced for it.
- Handshake:
  - mX_req is a valid-only request. mX_ready is combinational and is high in the same cycle mX_req is granted.
  - A request is accepted when req && ready. The master holds its request fields stable until accepted.
  - Masters cannot back-pressure read data: rvalid is a one-cycle pulse that must be consumed.
- Arbitration (combinational, every cycle):
  - Only one master requesting: it is granted.
  - Both requesting, FIXED_PRIO=1: master 0 is granted.
  - Both requesting, FIXED_PRIO=0: the master other than the last-granted one is granted.
  - The pointer updates only on a grant. It is not updated in idle cycles.
  - Throughput is 1 access per cycle, with no bubbles between back-to-back grants.
- SRAM drive (combinational from the granted master):
  - Granted read: CEN=0, GWEN=1, BEN=4'hF, A=addr, D=wdata (don't-care).
  - Granted write with be!=0: CEN=0, GWEN=0, BEN=~be, A=addr, D=wdata.
  - Granted write with be==0: accepted (ready=1) but is a no-op. CEN=1, GWEN=1, BEN=4'hF. No response.
  - No grant: CEN=1, GWEN=1, BEN=4'hF; A and D hold their last value.
- Read return:
  - A 1-bit owner tag and a read flag are pipelined alongside the access.
  - REG_OUT=0: read accepted in cycle N gives mX_rvalid=1 in cycle N+1 with mX_rdata=sram_q.
  - REG_OUT=1: rvalid is delayed to cycle N+2 and rdata comes from a register capturing sram_q in cycle N+1.
  - The non-owning master's rvalid stays 0. Its rdata holds its last value; it is not updated.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating masters return in order, one per cycle, each to its owner.
- Boundaries:
  - Address 14'h3FFF is a valid access; addresses do not wrap or get translated.
  - A read of an address written in the previous cycle returns the new data (SRAM ordering). The arbiter adds no forwarding.
  - A request held through RST is accepted normally in the first cycle after RST falls.

Test Plan:
- Reset: hold RST=1 for 3 cycles with m0_req=m1_req=1 -> ready=0, SRAM_CEN=1, SRAM_BEN=4'hF, rvalid=0 in all three cycles.
- Write then read: m0 writes addr 14'h0010, be=4'hF, wdata=32'hDEADBEEF; next cycle m0 reads 14'h0010 -> SRAM_GWEN=0/BEN=4'h0 on the write cycle; m0_rvalid one cycle after the read (REG_OUT=0) with m0_rdata=32'hDEADBEEF; m1_rvalid stays 0.
- Partial write: m1 writes addr 14'h3FFF, be=4'b0101, wdata=32'h11223344 over prior 32'hAAAAAAAA; then reads it -> SRAM_BEN=4'b1010 during the write; m1_rdata=32'hAA22AA44.
- Round-robin: both masters request reads continuously for 6 cycles (FIXED_PRIO=0) -> grants 0,1,0,1,0,1. Each rvalid goes to the issuing master with correct data, in order. With FIXED_PRIO=1 -> m0 is granted all 6 cycles and m1_ready stays 0.
- No-op write: m0 write with be=4'h0 -> m0_ready=1, SRAM_CEN=1, memory unchanged, no rvalid.
- Reset mid-read (REG_OUT=1): RST asserted the cycle after a read is accepted -> no rvalid on either master; the arbiter pointer returns to master 0.

Source files
------------

// File: rtl/sram_sp_arb_2m.sv
// Two-master arbiter and sequencer for the single-port 16384x32 byte-enabled SRAM wrapper.
// One access per cycle; read data returns with fixed latency, tagged to the issuing master.
module sram_sp_arb_2m #(
    parameter int FIXED_PRIO = 0,
    parameter int REG_OUT    = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        m0_req,
    output logic        m0_ready,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [13:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    output logic        m1_ready,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [13:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    input  logic [31:0] sram_q,
    output logic        SRAM_CEN,
    output logic        SRAM_GWEN,
    output logic [3:0]  SRAM_BEN,
    output logic [13:0] SRAM_A,
    output logic [31:0] SRAM_D
);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [13:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       sel;
    logic        gnt_valid;
    logic        gnt_id;
    logic        rr_ptr_q, rr_ptr_d;
    logic [13:0] a_q, a_d;
    logic [31:0] d_q, d_d;
    logic        rd_go;
    logic        s1_rd_q, s1_own_q;
    logic        ret_v, ret_own;
    logic [31:0] ret_data;
    logic [31:0] hold0_q, hold1_q;

    // rr_ptr_q names the master that wins the next tie; it moves only when someone is granted.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!RST) begin
            case ({m1_req, m0_req})
                2'b01:   gnt_valid = 1'b1;
                2'b10:   begin gnt_valid = 1'b1; gnt_id = 1'b1; end
                2'b11:   begin gnt_valid = 1'b1; gnt_id = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_q; end
                default: ;
            endcase
        end
        m0_ready = gnt_valid & ~gnt_id;
        m1_ready = gnt_valid & gnt_id;
        rr_ptr_d = gnt_valid ? ~gnt_id : rr_ptr_q;
        sel      = gnt_id ? {m1_we, m1_be, m1_addr, m1_wdata}
                          : {m0_we, m0_be, m0_addr, m0_wdata};
    end

    always_comb begin
        SRAM_CEN  = 1'b1;
        SRAM_GWEN = 1'b1;
        SRAM_BEN  = 4'hF;
        a_d       = a_q;
        d_d       = d_q;
        rd_go     = 1'b0;
        if (gnt_valid) begin
            a_d = sel.addr;
            d_d = sel.wdata;
            if (!sel.we) begin
                SRAM_CEN = 1'b0;
                rd_go    = 1'b1;
            end else if (sel.be != 4'h0) begin
                SRAM_CEN  = 1'b0;
                SRAM_GWEN = 1'b0;
                SRAM_BEN  = ~sel.be;
            end
        end
    end

    // Forced to zero during reset, before the hold registers have had an edge to clear.
    assign SRAM_A = RST ? 14'h0 : a_d;
    assign SRAM_D = RST ? 32'h0 : d_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: state updates use <= so every register samples the pre-edge values.
            rr_ptr_q <= 1'b0;
            a_q      <= 14'h0;
            d_q      <= 32'h0;
            s1_rd_q  <= 1'b0;
            s1_own_q <= 1'b0;
            hold0_q  <= 32'h0;
            hold1_q  <= 32'h0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            d_q      <= d_d;
            s1_rd_q  <= rd_go;
            s1_own_q <= gnt_id;
            if (m0_rvalid) hold0_q <= ret_data;
            if (m1_rvalid) hold1_q <= ret_data;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic        s2_rd_q, s2_own_q;
        logic [31:0] s2_data_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                s2_rd_q  <= 1'b0;
                s2_own_q <= 1'b0;
            end else begin
                s2_rd_q  <= s1_rd_q;
                s2_own_q <= s1_own_q;
            end
        end

        // NOTE: the data register is left unreset; it is only ever observed alongside s2_rd_q.
        always_ff @(posedge CLK) begin
            s2_data_q <= sram_q;
        end

        assign ret_v    = s2_rd_q;
        assign ret_own  = s2_own_q;
        assign ret_data = s2_data_q;
    end else begin : g_pass
        assign ret_v    = s1_rd_q;
        assign ret_own  = s1_own_q;
        assign ret_data = sram_q;
    end

    assign m0_rvalid = ~RST & ret_v & ~ret_own;
    assign m1_rvalid = ~RST & ret_v & ret_own;
    assign m0_rdata  = RST ? 32'h0 : (m0_rvalid ? ret_data : hold0_q);
    assign m1_rdata  = RST ? 32'h0 : (m1_rvalid ? ret_data : hold1_q);

endmodule

// File: tb/tb_sram_sp_arb_2m.sv
// Bench for sram_sp_arb_2m: two instances (round-robin/pass-through and fixed-priority/registered)
// share one directed stimulus; each drives its own SRAM model and is checked against a reference model.
module tb_sram_sp_arb_2m;

    localparam bit [1:0] FP = 2'b10;   // instance 1 uses fixed priority
    localparam bit [1:0] RO = 2'b10;   // instance 1 registers read data

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  be0 = 4'h0, be1 = 4'h0;
    logic [13:0] addr0 = 14'h0, addr1 = 14'h0;
    logic [31:0] wd0 = 32'h0, wd1 = 32'h0;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0  [2];
    logic        rv1  [2];
    logic [31:0] rd0  [2];
    logic [31:0] rd1  [2];
    logic        cen  [2];
    logic        gwen [2];
    logic [3:0]  ben  [2];
    logic [13:0] sa   [2];
    logic [31:0] sd   [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] q = 32'h0;
        bit   [31:0] mem [16384];

        sram_sp_arb_2m #(
            .FIXED_PRIO(int'(FP[gi])),
            .REG_OUT   (int'(RO[gi]))
        ) u_dut (
            .CLK      (CLK),
            .RST      (RST),
            .m0_req   (req0),
            .m0_ready (rdy0[gi]),
            .m0_we    (we0),
            .m0_be    (be0),
            .m0_addr  (addr0),
            .m0_wdata (wd0),
            .m0_rvalid(rv0[gi]),
            .m0_rdata (rd0[gi]),
            .m1_req   (req1),
            .m1_ready (rdy1[gi]),
            .m1_we    (we1),
            .m1_be    (be1),
            .m1_addr  (addr1),
            .m1_wdata (wd1),
            .m1_rvalid(rv1[gi]),
            .m1_rdata (rd1[gi]),
            .sram_q   (q),
            .SRAM_CEN (cen[gi]),
            .SRAM_GWEN(gwen[gi]),
            .SRAM_BEN (ben[gi]),
            .SRAM_A   (sa[gi]),
            .SRAM_D   (sd[gi])
        );

        // Synchronous single-port SRAM: Q is valid the cycle after a read; writes leave Q alone.
        always @(posedge CLK) begin
            if (cen[gi] == 1'b0) begin
                if (gwen[gi] == 1'b0) begin
                    for (int b = 0; b < 4; b++)
                        if (ben[gi][b] == 1'b0) mem[sa[gi]][8*b +: 8] <= sd[gi][8*b +: 8];
                end else begin
                    q <= mem[sa[gi]];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: grant rules, byte-masked memory and a queue of reads due at a given cycle.
    typedef struct {
        int        dut;
        int        due;
        int        own;
        bit [31:0] data;
    } rd_t;

    rd_t       pend [$];
    bit        tie_to [2];
    bit [31:0] hold [2][2];
    bit [13:0] last_a [2];
    bit [31:0] last_d [2];
    bit [31:0] ref_mem [2][16384];

    task automatic model_and_compare(input int k);
        bit        rq [2];
        bit        wv [2];
        bit [3:0]  bv [2];
        bit [13:0] av [2];
        bit [31:0] dv [2];
        bit        e_rdy [2];
        bit        e_rv [2];
        bit [31:0] e_rd [2];
        bit        e_cen, e_gwen;
        bit [3:0]  e_ben;
        bit [13:0] e_a;
        bit [31:0] e_d;
        int        g;
        rq[0] = req0; wv[0] = we0; bv[0] = be0; av[0] = addr0; dv[0] = wd0;
        rq[1] = req1; wv[1] = we1; bv[1] = be1; av[1] = addr1; dv[1] = wd1;
        for (int m = 0; m < 2; m++) begin
            e_rdy[m] = 1'b0;
            e_rv[m]  = 1'b0;
        end
        e_cen = 1'b1; e_gwen = 1'b1; e_ben = 4'hF;
        if (RST) begin
            tie_to[k] = 1'b0;
            hold[k][0] = 32'h0;
            hold[k][1] = 32'h0;
            last_a[k] = 14'h0;
            last_d[k] = 32'h0;
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].dut == k) pend.delete(i);
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].dut == k && pend[i].due == cyc) begin
                    e_rv[pend[i].own] = 1'b1;
                    hold[k][pend[i].own] = pend[i].data;
                    pend.delete(i);
                end
            end
            if (rq[0] || rq[1]) begin
                if (rq[0] && rq[1]) g = FP[k] ? 0 : int'(tie_to[k]);
                else g = rq[1] ? 1 : 0;
                e_rdy[g]  = 1'b1;
                tie_to[k] = (g == 0);
                last_a[k] = av[g];
                last_d[k] = dv[g];
                if (!wv[g]) begin
                    e_cen = 1'b0;
                    pend.push_back('{dut: k, due: cyc + 1 + int'(RO[k]), own: g, data: ref_mem[k][av[g]]});
                end else if (bv[g] != 4'h0) begin
                    e_cen  = 1'b0;
                    e_gwen = 1'b0;
                    e_ben  = ~bv[g];
                    for (int b = 0; b < 4; b++)
                        if (bv[g][b]) ref_mem[k][av[g]][8*b +: 8] = dv[g][8*b +: 8];
                end
            end
        end
        e_rd[0] = hold[k][0];
        e_rd[1] = hold[k][1];
        e_a = last_a[k];
        e_d = last_d[k];
        check($sformatf("dut%0d c%0d m0_ready", k, cyc), rdy0[k], e_rdy[0]);
        check($sformatf("dut%0d c%0d m1_ready", k, cyc), rdy1[k], e_rdy[1]);
        check($sformatf("dut%0d c%0d m0_rvalid", k, cyc), rv0[k], e_rv[0]);
        check($sformatf("dut%0d c%0d m1_rvalid", k, cyc), rv1[k], e_rv[1]);
        check($sformatf("dut%0d c%0d m0_rdata", k, cyc), rd0[k], e_rd[0]);
        check($sformatf("dut%0d c%0d m1_rdata", k, cyc), rd1[k], e_rd[1]);
        check($sformatf("dut%0d c%0d SRAM_CEN", k, cyc), cen[k], e_cen);
        check($sformatf("dut%0d c%0d SRAM_GWEN", k, cyc), gwen[k], e_gwen);
        check($sformatf("dut%0d c%0d SRAM_BEN", k, cyc), ben[k], e_ben);
        check($sformatf("dut%0d c%0d SRAM_A", k, cyc), sa[k], e_a);
        check($sformatf("dut%0d c%0d SRAM_D", k, cyc), sd[k], e_d);
    endtask

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) model_and_compare(k);
        cyc++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_m(input int m, input logic r, input logic w, input logic [3:0] b,
                         input logic [13:0] a, input logic [31:0] d);
        if (m == 0) begin
            req0 = r; we0 = w; be0 = b; addr0 = a; wd0 = d;
        end else begin
            req1 = r; we1 = w; be1 = b; addr1 = a; wd1 = d;
        end
    endtask

    task automatic idle();
        set_m(0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    endtask

    initial begin
        // Reset held three cycles with both masters requesting.
        set_m(0, 1'b1, 1'b0, 4'hF, 14'h0005, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 14'h0006, 32'h0);
        repeat (3) begin
            @(negedge CLK);
            check("lit rst m0_ready", rdy0[0], 1'b0);
            check("lit rst m1_ready", rdy1[0], 1'b0);
            check("lit rst SRAM_CEN", cen[0], 1'b1);
            check("lit rst SRAM_BEN", ben[0], 4'hF);
            check("lit rst m0_rvalid", rv0[1], 1'b0);
        end
        tick(); RST = 1'b0;
        @(negedge CLK);
        check("lit post-rst m0 granted", rdy0[0], 1'b1);
        check("lit post-rst m1 waits", rdy1[0], 1'b0);
        tick(); set_m(0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        @(negedge CLK);
        check("lit post-rst m1 granted", rdy1[0], 1'b1);
        tick(); idle();

        // Full write then read-back by master 0.
        tick(); set_m(0, 1'b1, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF);
        @(negedge CLK);
        check("lit wr SRAM_GWEN", gwen[0], 1'b0);
        check("lit wr SRAM_BEN", ben[0], 4'h0);
        tick(); set_m(0, 1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        tick(); idle();
        @(negedge CLK);
        check("lit rd m0_rvalid", rv0[0], 1'b1);
        check("lit rd m0_rdata", rd0[0], 32'hDEADBEEF);
        check("lit rd m1_rvalid", rv1[0], 1'b0);
        tick();
        @(negedge CLK);
        check("lit rd regout m0_rvalid", rv0[1], 1'b1);
        check("lit rd regout m0_rdata", rd0[1], 32'hDEADBEEF);

        // Partial write at the top address by master 1.
        tick(); set_m(1, 1'b1, 1'b1, 4'hF, 14'h3FFF, 32'hAAAAAAAA);
        tick(); set_m(1, 1'b1, 1'b1, 4'b0101, 14'h3FFF, 32'h11223344);
        @(negedge CLK);
        check("lit partial SRAM_BEN", ben[0], 4'b1010);
        tick(); set_m(1, 1'b1, 1'b0, 4'hF, 14'h3FFF, 32'h0);
        tick(); idle();
        @(negedge CLK);
        check("lit partial m1_rvalid", rv1[0], 1'b1);
        check("lit partial m1_rdata", rd1[0], 32'hAA22AA44);
        tick();
        @(negedge CLK);
        check("lit partial regout m1_rdata", rd1[1], 32'hAA22AA44);

        // Both masters reading continuously for six cycles.
        tick();
        set_m(0, 1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 14'h3FFF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) tick();
            @(negedge CLK);
            check($sformatf("lit rr%0d m0_ready", i), rdy0[0], (i % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("lit fixed%0d m0_ready", i), rdy0[1], 1'b1);
            check($sformatf("lit fixed%0d m1_ready", i), rdy1[1], 1'b0);
        end
        tick(); idle();
        repeat (2) tick();

        // Write with no byte enables is accepted but leaves memory alone.
        set_m(0, 1'b1, 1'b1, 4'h0, 14'h0010, 32'h0BADF00D);
        @(negedge CLK);
        check("lit noop m0_ready", rdy0[0], 1'b1);
        check("lit noop SRAM_CEN", cen[0], 1'b1);
        tick(); set_m(0, 1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        tick(); idle();
        @(negedge CLK);
        check("lit noop readback", rd0[0], 32'hDEADBEEF);
        repeat (2) tick();

        // Reset the cycle after a read is accepted.
        set_m(0, 1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        tick(); idle(); RST = 1'b1;
        @(negedge CLK);
        check("lit rstmid m0_rvalid", rv0[0], 1'b0);
        tick(); RST = 1'b0;
        set_m(0, 1'b1, 1'b0, 4'hF, 14'h0010, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 14'h3FFF, 32'h0);
        @(negedge CLK);
        check("lit rstmid regout m0_rvalid", rv0[1], 1'b0);
        check("lit rstmid ptr m0_ready", rdy0[0], 1'b1);
        check("lit rstmid ptr m1_ready", rdy1[0], 1'b0);
        tick(); set_m(0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        tick(); idle();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
